// File: rtl/wb_counter_ctrl_if.sv
// Wishbone slave bundle between the AHB-to-FPGA bridge and the counter controller.
interface wb_counter_ctrl_if #(
  parameter int ADDRWIDTH = 7,
  parameter int DATAWIDTH = 32
) ();

  logic [ADDRWIDTH-1:0] WBs_ADR;
  logic                 WBs_CYC;
  logic                 WBs_STB;
  logic                 WBs_WE;
  logic [3:0]           WBs_BYTE_STB;
  logic [DATAWIDTH-1:0] WBs_WR_DAT;
  logic [DATAWIDTH-1:0] WBs_RD_DAT;
  logic                 WBs_ACK;

  modport master (
    output WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_BYTE_STB, WBs_WR_DAT,
    input  WBs_RD_DAT, WBs_ACK
  );

  modport slave (
    input  WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_BYTE_STB, WBs_WR_DAT,
    output WBs_RD_DAT, WBs_ACK
  );

endinterface

// File: rtl/wb_counter_ctrl.sv
// Wishbone-controlled sequencer for the 32-bit fabric counter: start/stop/clear
// commands, one-shot or periodic runs, sticky done/overflow/busy status flags.
// The byte-lane logic assumes DATAWIDTH = 32 (four byte strobes).
module wb_counter_ctrl #(
  parameter int                   ADDRWIDTH          = 7,
  parameter int                   DATAWIDTH          = 32,
  parameter logic [DATAWIDTH-1:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RST,
  wb_counter_ctrl_if.slave     wb,
  output logic [DATAWIDTH-1:0] count,
  output logic                 cnt_run,
  output logic                 cnt_irq
);

  localparam logic [ADDRWIDTH-1:0] ADDR_CTRL   = ADDRWIDTH'(0);
  localparam logic [ADDRWIDTH-1:0] ADDR_LOAD   = ADDRWIDTH'(1);
  localparam logic [ADDRWIDTH-1:0] ADDR_LIMIT  = ADDRWIDTH'(2);
  localparam logic [ADDRWIDTH-1:0] ADDR_STATUS = ADDRWIDTH'(3);
  localparam logic [ADDRWIDTH-1:0] ADDR_COUNT  = ADDRWIDTH'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DATAWIDTH-1:0] count_q, count_d;
  logic [DATAWIDTH-1:0] load_q, load_d;
  logic [DATAWIDTH-1:0] limit_q, limit_d;
  logic [DATAWIDTH-1:0] rd_dat_q, rd_dat_d;
  logic                 mode_q, mode_d;
  logic                 irq_en_q, irq_en_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic                 err_q, err_d;
  logic                 ack_q, ack_d;
  logic                 run_q, run_d;
  logic                 irq_q, irq_d;

  logic                 req;
  logic                 wr;
  logic                 ctrl_wr;
  logic                 cmd_start;
  logic                 cmd_stop;
  logic                 cmd_clear;
  logic [3:0]           w1c;
  logic [DATAWIDTH-1:0] rd_mux;
  logic                 done_set;
  logic                 ovf_set;
  logic                 err_set;

  // A new request is only recognised when the previous one is not being acked,
  // which spaces back-to-back transfers to every other cycle.
  assign req       = wb.WBs_CYC & wb.WBs_STB & ~ack_q;
  assign wr        = req & wb.WBs_WE;
  assign ctrl_wr   = wr & (wb.WBs_ADR == ADDR_CTRL) & wb.WBs_BYTE_STB[0];
  assign cmd_start = ctrl_wr & wb.WBs_WR_DAT[0];
  assign cmd_stop  = ctrl_wr & wb.WBs_WR_DAT[1];
  assign cmd_clear = ctrl_wr & wb.WBs_WR_DAT[2];
  assign w1c       = (wr && (wb.WBs_ADR == ADDR_STATUS) && wb.WBs_BYTE_STB[0]) ?
                     wb.WBs_WR_DAT[3:0] : 4'b0000;

  function automatic logic [DATAWIDTH-1:0] merge_bytes(
    input logic [DATAWIDTH-1:0] old_val,
    input logic [DATAWIDTH-1:0] new_val,
    input logic [3:0]           be
  );
    logic [DATAWIDTH-1:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Read mux over the register values as they stand before the sampling edge.
  always_comb begin
    rd_mux = DEFAULT_READ_VALUE;
    case (wb.WBs_ADR)
      ADDR_CTRL: begin
        rd_mux    = '0;
        rd_mux[4] = mode_q;
        rd_mux[5] = irq_en_q;
      end
      ADDR_LOAD:  rd_mux = load_q;
      ADDR_LIMIT: rd_mux = limit_q;
      ADDR_STATUS: begin
        rd_mux    = '0;
        rd_mux[0] = (state_q == RUN);
        rd_mux[1] = done_q;
        rd_mux[2] = ovf_q;
        rd_mux[3] = err_q;
      end
      ADDR_COUNT: rd_mux = count_q;
      default:    rd_mux = DEFAULT_READ_VALUE;
    endcase
  end

  // Next-state logic: bus register writes, then counter sequencing with
  // CLEAR > STOP > START priority; hardware flag sets override same-edge W1C.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    load_d   = load_q;
    limit_d  = limit_q;
    mode_d   = mode_q;
    irq_en_d = irq_en_q;
    done_set = 1'b0;
    ovf_set  = 1'b0;
    err_set  = 1'b0;
    ack_d    = req;
    rd_dat_d = req ? rd_mux : rd_dat_q;

    if (ctrl_wr) begin
      mode_d   = wb.WBs_WR_DAT[4];
      irq_en_d = wb.WBs_WR_DAT[5];
    end
    if (wr && (wb.WBs_ADR == ADDR_LOAD)) begin
      load_d = merge_bytes(load_q, wb.WBs_WR_DAT, wb.WBs_BYTE_STB);
    end
    if (wr && (wb.WBs_ADR == ADDR_LIMIT)) begin
      limit_d = merge_bytes(limit_q, wb.WBs_WR_DAT, wb.WBs_BYTE_STB);
    end

    if (cmd_clear) begin
      state_d = IDLE;
      count_d = '0;
    end else if (cmd_stop) begin
      if (state_q == RUN) state_d = IDLE;
    end else if (cmd_start && (state_q != RUN)) begin
      state_d = RUN;
      count_d = load_q;
    end else if (state_q == RUN) begin
      if (cmd_start) err_set = 1'b1;
      if (count_q == limit_q) begin
        done_set = 1'b1;
        if (mode_q) count_d = load_q;
        else        state_d = DONE;
      end else begin
        count_d = count_q + 1'b1;
        if (&count_q) ovf_set = 1'b1;
      end
    end

    done_d = (done_q & ~w1c[1]) | done_set;
    ovf_d  = (ovf_q  & ~w1c[2]) | ovf_set;
    err_d  = (err_q  & ~w1c[3]) | err_set;
    run_d  = (state_d == RUN);
    irq_d  = done_d & irq_en_d;
  end

  // All state, including the registered outputs, updates here with synchronous reset.
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      state_q  <= IDLE;
      count_q  <= '0;
      load_q   <= '0;
      limit_q  <= '1;
      rd_dat_q <= '0;
      mode_q   <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
      run_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      load_q   <= load_d;
      limit_q  <= limit_d;
      rd_dat_q <= rd_dat_d;
      mode_q   <= mode_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      run_q    <= run_d;
      irq_q    <= irq_d;
    end
  end

  assign wb.WBs_ACK    = ack_q;
  assign wb.WBs_RD_DAT = rd_dat_q;
  assign count         = count_q;
  assign cnt_run       = run_q;
  assign cnt_irq       = irq_q;

endmodule

// File: tb/tb_wb_counter_ctrl.sv
// Self-checking bench for wb_counter_ctrl: directed scenarios plus random bus
// traffic, all compared cycle by cycle against a rule-level reference model.
module tb_wb_counter_ctrl;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  logic        WB_CLK = 1'b0;
  logic        WB_RST = 1'b1;
  logic [31:0] count;
  logic        cnt_run;
  logic        cnt_irq;

  int total = 0;
  int bad   = 0;

  // Reference model state (value after the most recent clock edge)
  int          mPhase;
  logic [31:0] mCount, mLoad, mLimit, mRd;
  bit          mMode, mIrqEn, mDone, mOvf, mErr, mAck;

  wb_counter_ctrl_if #(.ADDRWIDTH(7), .DATAWIDTH(32)) bus ();

  wb_counter_ctrl #(
    .ADDRWIDTH(7),
    .DATAWIDTH(32),
    .DEFAULT_READ_VALUE(32'hBADFABAC)
  ) dut (
    .WB_CLK (WB_CLK),
    .WB_RST (WB_RST),
    .wb     (bus),
    .count  (count),
    .cnt_run(cnt_run),
    .cnt_irq(cnt_irq)
  );

  // Free-running fabric clock
  always #5 WB_CLK = ~WB_CLK;

  // Hard time limit so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] byteMask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] modelRead(input logic [6:0] adr);
    logic [31:0] r;
    r = '0;
    if (adr == 7'd0) begin
      r[4] = mMode;
      r[5] = mIrqEn;
    end else if (adr == 7'd1) r = mLoad;
    else if (adr == 7'd2) r = mLimit;
    else if (adr == 7'd3) begin
      r[0] = (mPhase == PH_RUN);
      r[1] = mDone;
      r[2] = mOvf;
      r[3] = mErr;
    end else if (adr == 7'd4) r = mCount;
    else r = 32'hBADFABAC;
    return r;
  endfunction

  // One clock: predict the post-edge state from the rules, step the clock,
  // then compare every visible output at the falling edge.
  task automatic tick();
    bit          req, wr, cStart, cStop, cClear, doneSet, ovfSet, errSet;
    int          nPhase;
    logic [31:0] nCount, nLoad, nLimit, nRd, msk;
    bit          nMode, nIrqEn;
    logic [3:0]  w1c;
    req = bus.WBs_CYC && bus.WBs_STB && !mAck;
    wr  = req && bus.WBs_WE;
    nPhase = mPhase; nCount = mCount; nLoad = mLoad; nLimit = mLimit;
    nMode = mMode; nIrqEn = mIrqEn;
    nRd = req ? modelRead(bus.WBs_ADR) : mRd;
    cStart = 0; cStop = 0; cClear = 0; doneSet = 0; ovfSet = 0; errSet = 0;
    w1c = 4'b0;
    msk = byteMask(bus.WBs_BYTE_STB);
    if (wr) begin
      if (bus.WBs_ADR == 7'd0 && bus.WBs_BYTE_STB[0]) begin
        nMode  = bus.WBs_WR_DAT[4];
        nIrqEn = bus.WBs_WR_DAT[5];
        cStart = bus.WBs_WR_DAT[0];
        cStop  = bus.WBs_WR_DAT[1];
        cClear = bus.WBs_WR_DAT[2];
      end else if (bus.WBs_ADR == 7'd1) nLoad = (mLoad & ~msk) | (bus.WBs_WR_DAT & msk);
      else if (bus.WBs_ADR == 7'd2) nLimit = (mLimit & ~msk) | (bus.WBs_WR_DAT & msk);
      else if (bus.WBs_ADR == 7'd3 && bus.WBs_BYTE_STB[0]) w1c = bus.WBs_WR_DAT[3:0];
    end
    if (cClear) begin
      nPhase = PH_IDLE;
      nCount = 0;
    end else if (cStop) begin
      if (mPhase == PH_RUN) nPhase = PH_IDLE;
    end else if (cStart && mPhase != PH_RUN) begin
      nPhase = PH_RUN;
      nCount = mLoad;
    end else if (mPhase == PH_RUN) begin
      errSet = cStart;
      if (mCount == mLimit) begin
        doneSet = 1;
        if (mMode) nCount = mLoad;
        else nPhase = PH_DONE;
      end else begin
        nCount = mCount + 32'd1;
        ovfSet = (nCount == 32'd0);
      end
    end
    @(posedge WB_CLK);
    if (WB_RST) begin
      mPhase = PH_IDLE; mCount = 0; mLoad = 0; mLimit = 32'hFFFFFFFF; mRd = 0;
      mMode = 0; mIrqEn = 0; mDone = 0; mOvf = 0; mErr = 0; mAck = 0;
    end else begin
      mPhase = nPhase; mCount = nCount; mLoad = nLoad; mLimit = nLimit; mRd = nRd;
      mMode = nMode; mIrqEn = nIrqEn; mAck = req;
      mDone = (mDone && !w1c[1]) || doneSet;
      mOvf  = (mOvf  && !w1c[2]) || ovfSet;
      mErr  = (mErr  && !w1c[3]) || errSet;
    end
    @(negedge WB_CLK);
    checkOutput("count", count, mCount);
    checkOutput("cnt_run", 32'(cnt_run), 32'(mPhase == PH_RUN));
    checkOutput("cnt_irq", 32'(cnt_irq), 32'(mDone && mIrqEn));
    checkOutput("ack", 32'(bus.WBs_ACK), 32'(mAck));
    if (mAck) checkOutput("rd_dat", bus.WBs_RD_DAT, mRd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One Wishbone transfer; waits a bounded number of cycles for the ack.
  task automatic applyStimulus(input logic [6:0] adr, input bit we, input logic [31:0] dat,
                               input logic [3:0] be, output logic [31:0] rd);
    bit got;
    got = 0;
    rd  = '0;
    bus.WBs_ADR = adr; bus.WBs_WE = we; bus.WBs_WR_DAT = dat; bus.WBs_BYTE_STB = be;
    bus.WBs_CYC = 1'b1; bus.WBs_STB = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      if (bus.WBs_ACK) begin
        got = 1;
        rd  = bus.WBs_RD_DAT;
      end
    end
    if (!got) checkOutput("ack_timeout", 32'd0, 32'd1);
    bus.WBs_CYC = 1'b0; bus.WBs_STB = 1'b0; bus.WBs_WE = 1'b0;
  endtask

  task automatic busWrite(input logic [6:0] adr, input logic [31:0] dat);
    logic [31:0] unused;
    applyStimulus(adr, 1'b1, dat, 4'hF, unused);
  endtask

  task automatic readCheck(input string tag, input logic [6:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    applyStimulus(adr, 1'b0, 32'd0, 4'hF, rd);
    checkOutput(tag, rd, exp);
  endtask

  task automatic waitCount(input logic [31:0] target, input int budget);
    int n;
    n = 0;
    while (mCount != target && n < budget) begin
      tick();
      n++;
    end
    if (mCount != target) checkOutput("wait_count_timeout", mCount, target);
  endtask

  // Directed scenarios followed by random traffic
  initial begin
    logic [31:0] held, rdv, dat;
    logic [6:0]  adr;
    logic [3:0]  be;
    mPhase = PH_IDLE; mCount = 0; mLoad = 0; mLimit = 32'hFFFFFFFF; mRd = 0;
    mMode = 0; mIrqEn = 0; mDone = 0; mOvf = 0; mErr = 0; mAck = 0;
    bus.WBs_ADR = '0; bus.WBs_CYC = 0; bus.WBs_STB = 0; bus.WBs_WE = 0;
    bus.WBs_BYTE_STB = 4'hF; bus.WBs_WR_DAT = '0;
    @(negedge WB_CLK);
    WB_RST = 1'b1;
    idle(2);
    WB_RST = 1'b0;
    idle(1);
    readCheck("limit_reset", 7'd2, 32'hFFFFFFFF);
    readCheck("status_reset", 7'd3, 32'd0);

    // Undefined address and byte-masked LOAD write
    readCheck("bad_addr", 7'h7F, 32'hBADFABAC);
    tick();
    checkOutput("ack_one_cycle", 32'(bus.WBs_ACK), 32'd0);
    applyStimulus(7'd1, 1'b1, 32'hAABBCCDD, 4'b0010, rdv);
    readCheck("load_bytes", 7'd1, 32'h0000CC00);

    // One-shot 5..8 with interrupt
    busWrite(7'd1, 32'd5);
    busWrite(7'd2, 32'd8);
    busWrite(7'd0, 32'h21);
    checkOutput("oneshot_first", count, 32'd5);
    idle(6);
    checkOutput("oneshot_hold", count, 32'd8);
    checkOutput("oneshot_irq", 32'(cnt_irq), 32'd1);
    readCheck("oneshot_status", 7'd3, 32'h2);
    busWrite(7'd3, 32'h2);
    checkOutput("irq_cleared", 32'(cnt_irq), 32'd0);

    // Wrap through zero sets ovf
    busWrite(7'd1, 32'hFFFFFFFE);
    busWrite(7'd2, 32'd1);
    busWrite(7'd0, 32'h01);
    idle(6);
    readCheck("wrap_status", 7'd3, 32'h6);
    checkOutput("wrap_count", count, 32'd1);

    // Periodic run, busy START, W1C racing a reload, then STOP
    busWrite(7'd3, 32'hF);
    busWrite(7'd1, 32'd0);
    busWrite(7'd2, 32'd3);
    busWrite(7'd0, 32'h31);
    idle(9);
    checkOutput("periodic_run", 32'(cnt_run), 32'd1);
    busWrite(7'd0, 32'h31);
    readCheck("busy_err", 7'd3, 32'hB);
    waitCount(32'd3, 12);
    busWrite(7'd3, 32'h2);
    checkOutput("w1c_race_irq", 32'(cnt_irq), 32'd1);
    checkOutput("w1c_race_reload", count, 32'd0);
    busWrite(7'd0, 32'h22);
    held = mCount;
    readCheck("count_held_a", 7'd4, held);
    readCheck("count_held_b", 7'd4, held);

    // CLEAR beats STOP and START in the same write
    busWrite(7'd0, 32'h11);
    idle(2);
    busWrite(7'd0, 32'h07);
    checkOutput("clr_count", count, 32'd0);
    checkOutput("clr_run", 32'(cnt_run), 32'd0);

    // Reset mid-run with a request pending
    busWrite(7'd0, 32'h11);
    idle(3);
    bus.WBs_ADR = 7'd2; bus.WBs_WE = 1'b0; bus.WBs_CYC = 1'b1; bus.WBs_STB = 1'b1;
    WB_RST = 1'b1;
    tick();
    WB_RST = 1'b0;
    bus.WBs_CYC = 1'b0; bus.WBs_STB = 1'b0;
    checkOutput("rst_ack", 32'(bus.WBs_ACK), 32'd0);
    checkOutput("rst_count", count, 32'd0);
    checkOutput("rst_run", 32'(cnt_run), 32'd0);
    readCheck("rst_limit", 7'd2, 32'hFFFFFFFF);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      adr = (($urandom_range(0, 7) == 7) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4)));
      if (adr == 7'd0) dat = 32'($urandom_range(0, 255)) | ($urandom & 32'hFFFFFF00);
      else if ($urandom_range(0, 3) == 0) dat = 32'hFFFFFFF8 | 32'($urandom_range(0, 7));
      else dat = 32'($urandom_range(0, 12));
      be = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      applyStimulus(adr, 1'($urandom_range(0, 1)), dat, be, rdv);
      idle($urandom_range(0, 4));
      if ($urandom_range(0, 60) == 0) begin
        WB_RST = 1'b1;
        tick();
        WB_RST = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
